// File: rtl/rv_stream_arbiter.sv
// Round-robin N:1 ready/valid stream merger with grant locking and a
// selectable output stage (passthrough, two-entry skid buffer, or output register).
module rv_stream_arbiter #(
  parameter int NUM_REQS     = 4,
  parameter int DATAW        = 8,
  parameter int BUFFERED     = 1,
  parameter int LOG_NUM_REQS = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQS-1:0]       valid_in,
  input  logic [NUM_REQS*DATAW-1:0] data_in,
  output logic [NUM_REQS-1:0]       ready_in,
  output logic                      valid_out,
  output logic [DATAW-1:0]          data_out,
  output logic [LOG_NUM_REQS-1:0]   sel_out,
  input  logic                      ready_out
);

  if (NUM_REQS == 1) begin : g_single
    assign valid_out = valid_in[0];
    assign data_out  = data_in[DATAW-1:0];
    assign ready_in  = ready_out;
    assign sel_out   = '0;
  end else begin : g_arb
    typedef logic [LOG_NUM_REQS-1:0] idx_t;
    typedef struct packed {
      idx_t             sel;
      logic [DATAW-1:0] data;
    } beat_t;

    idx_t  rr_ptr, lock_idx, grant;
    logic  locked, grant_vld, stage_rdy, in_fire;
    beat_t in_beat;

    // Reverse scan so the candidate closest to rr_ptr+1 is assigned last and wins.
    always_comb begin
      idx_t cand;
      cand      = '0;
      grant     = lock_idx;
      grant_vld = valid_in[lock_idx];
      if (!locked) begin
        grant_vld = 1'b0;
        for (int i = NUM_REQS; i >= 1; i--) begin
          cand = idx_t'((int'(rr_ptr) + i) % NUM_REQS);
          if (valid_in[cand]) begin
            grant     = cand;
            grant_vld = 1'b1;
          end
        end
      end
    end

    // Reset gates the handshake so nothing is accepted while reset is held.
    assign in_fire = grant_vld && stage_rdy && reset;
    assign in_beat = '{sel: grant, data: data_in[grant*DATAW +: DATAW]};

    always_comb begin
      ready_in = '0;
      if (in_fire) ready_in[grant] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        rr_ptr   <= idx_t'(NUM_REQS - 1);
        locked   <= 1'b0;
        lock_idx <= '0;
      end else if (in_fire) begin
        rr_ptr <= grant;
        locked <= 1'b0;
      end else if (grant_vld) begin
        locked   <= 1'b1;
        lock_idx <= grant;
      end
    end

    if (BUFFERED == 0) begin : g_pass
      assign stage_rdy = ready_out;
      assign valid_out = grant_vld && reset;
      assign data_out  = reset ? in_beat.data : '0;
      assign sel_out   = reset ? in_beat.sel : '0;
    end else if (BUFFERED == 2) begin : g_oreg
      beat_t out_q;
      logic  out_vld;
      assign stage_rdy = !out_vld || ready_out;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          out_vld <= 1'b0;
          out_q   <= '0;
        end else if (stage_rdy) begin
          out_vld <= in_fire;
          if (in_fire) out_q <= in_beat;
        end
      end
      assign valid_out = out_vld;
      assign data_out  = out_q.data;
      assign sel_out   = out_q.sel;
    end else begin : g_skid
      beat_t out_q, skid_q;
      logic  out_vld, skid_vld;
      // ready_in comes straight from skid occupancy, never from ready_out.
      assign stage_rdy = !skid_vld;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          out_vld  <= 1'b0;
          skid_vld <= 1'b0;
          out_q    <= '0;
          skid_q   <= '0;
        end else if (!out_vld || ready_out) begin
          if (skid_vld) begin
            out_vld  <= 1'b1;
            out_q    <= skid_q;
            skid_vld <= 1'b0;
          end else begin
            out_vld <= in_fire;
            if (in_fire) out_q <= in_beat;
          end
        end else if (in_fire) begin
          skid_vld <= 1'b1;
          skid_q   <= in_beat;
        end
      end
      assign valid_out = out_vld;
      assign data_out  = out_q.data;
      assign sel_out   = out_q.sel;
    end
  end

endmodule

// File: tb/tb_rv_stream_arbiter.sv
// Bench for rv_stream_arbiter: directed scenarios plus randomized traffic on all
// three output-stage variants, scored against a queue-based round-robin model.
module tb_rv_stream_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance k uses BUFFERED = k.
  logic [3:0]  vin  [3];
  logic [31:0] din  [3];
  logic [3:0]  rdy  [3];
  logic        vout [3];
  logic [7:0]  dout [3];
  logic [1:0]  sout [3];
  logic        rout [3];

  for (genvar k = 0; k < 3; k++) begin : g_dut
    rv_stream_arbiter #(.NUM_REQS(4), .DATAW(8), .BUFFERED(k)) u_dut (
      .clk(clk), .reset(rst_n), .valid_in(vin[k]), .data_in(din[k]),
      .ready_in(rdy[k]), .valid_out(vout[k]), .data_out(dout[k]),
      .sel_out(sout[k]), .ready_out(rout[k]));
  end

  logic       vin1, rdy1, vout1, rout1;
  logic [7:0] din1, dout1;
  logic [0:0] sout1;
  rv_stream_arbiter #(.NUM_REQS(1), .DATAW(8), .BUFFERED(1)) u_one (
    .clk(clk), .reset(rst_n), .valid_in(vin1), .data_in(din1),
    .ready_in(rdy1), .valid_out(vout1), .data_out(dout1),
    .sel_out(sout1), .ready_out(rout1));

  int checks = 0;
  int errors = 0;

  // Reference model: per-source payload counters, in-flight queue per instance,
  // and the round-robin grant committed when first offered.
  int       expq       [3][$];
  int       commit     [3];
  bit       has_commit [3];
  int       last       [3];
  bit       pend       [3][4];
  int       cnt        [3][4];
  bit       held       [3];
  logic [7:0] hd [3];
  logic [1:0] hs [3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int search(input int l, input logic [3:0] v);
    for (int o = 1; o <= 4; o++)
      if (v[(l + o) % 4]) return (l + o) % 4;
    return -1;
  endfunction

  task automatic model_reset(input int k);
    expq[k].delete();
    has_commit[k] = 1'b0;
    last[k] = 3;
    held[k] = 1'b0;
    for (int s = 0; s < 4; s++) pend[k][s] = 1'b0;
  endtask

  task automatic drive_src(input int k);
    for (int s = 0; s < 4; s++) begin
      vin[k][s] = pend[k][s];
      din[k][8*s +: 8] = {2'(s), 6'(cnt[k][s])};
    end
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      vin[k] = 4'hF; din[k] = 32'h5A5A5A5A; rout[k] = 1'b1;
    end
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_vout%0d", k), 32'(vout[k]), 0);
      chk($sformatf("rst_dout%0d", k), 32'(dout[k]), 0);
      chk($sformatf("rst_sel%0d", k), 32'(sout[k]), 0);
      chk($sformatf("rst_rdy%0d", k), 32'(rdy[k]), 0);
      vin[k] = 4'h0; rout[k] = 1'b0;
      model_reset(k);
    end
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  // Evaluate one cycle at the negedge; returns the source accepted (or -1).
  task automatic eval(input int k, output int acc);
    int occ, e;
    bit rc;
    logic [3:0] er;
    occ = expq[k].size();
    if (k == 0) chk("vout_pass", 32'(vout[k]), 32'(|vin[k]));
    else        chk("vout_occ", 32'(vout[k]), 32'(occ > 0));
    if (held[k]) begin
      chk("hold_data", 32'(dout[k]), 32'(hd[k]));
      chk("hold_sel", 32'(sout[k]), 32'(hs[k]));
    end
    if (!has_commit[k] && vin[k] != 4'h0) begin
      commit[k] = search(last[k], vin[k]);
      has_commit[k] = 1'b1;
    end
    case (k)
      0:       rc = rout[k];
      1:       rc = (occ < 2);
      default: rc = (occ == 0) || rout[k];
    endcase
    er = (has_commit[k] && rc) ? 4'(1 << commit[k]) : 4'h0;
    chk("ready_in", 32'(rdy[k]), 32'(er));
    acc = -1;
    for (int s = 0; s < 4; s++) if (vin[k][s] && rdy[k][s]) acc = s;
    if (acc >= 0) begin
      expq[k].push_back({acc[1:0], 6'(cnt[k][acc])});
      last[k] = acc;
      has_commit[k] = 1'b0;
    end
    if (vout[k] && rout[k]) begin
      if (expq[k].size() == 0) chk("out_nonempty", 32'(expq[k].size()), 1);
      else begin
        e = expq[k].pop_front();
        chk("data_out", 32'(dout[k]), 32'(e[7:0]));
        chk("sel_out", 32'(sout[k]), 32'(e[7:6]));
      end
    end
    held[k] = vout[k] && !rout[k];
    hd[k] = dout[k];
    hs[k] = sout[k];
  endtask

  // mode: 0 random ready, 1 toggle, 2 held high, 3 held low
  task automatic rcycle(input int k, input int pv, input int mode);
    int acc;
    @(negedge clk);
    eval(k, acc);
    @(posedge clk);
    #1;
    if (acc >= 0) begin
      cnt[k][acc]++;
      pend[k][acc] = 1'b0;
    end
    for (int s = 0; s < 4; s++)
      if (!pend[k][s] && $urandom_range(99) < pv) pend[k][s] = 1'b1;
    case (mode)
      0:       rout[k] = 1'($urandom_range(1));
      1:       rout[k] = ~rout[k];
      2:       rout[k] = 1'b1;
      default: rout[k] = 1'b0;
    endcase
    drive_src(k);
  endtask

  task automatic rphase(input int k, input int pv, input int mode, input int n);
    do_reset;
    for (int s = 0; s < 4; s++) pend[k][s] = 1'($urandom_range(1));
    rout[k] = 1'b1;
    drive_src(k);
    repeat (n) rcycle(k, pv, mode);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      for (int s = 0; s < 4; s++) cnt[k][s] = 0;
      vin[k] = 4'h0; din[k] = 32'h0; rout[k] = 1'b0;
    end
    vin1 = 1'b0; din1 = 8'h0; rout1 = 1'b0;

    // Skid buffer, all sources valid, sustained A0..A3 rotation after one cycle.
    do_reset;
    vin[1] = 4'hF; din[1] = 32'hA3A2A1A0; rout[1] = 1'b1;
    @(negedge clk);
    chk("b1_first_vout", 32'(vout[1]), 0);
    chk("b1_first_rdy", 32'(rdy[1]), 32'h1);
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      chk("b1_seq_vout", 32'(vout[1]), 1);
      chk("b1_seq_sel", 32'(sout[1]), 32'(n % 4));
      chk("b1_seq_data", 32'(dout[1]), 32'(8'hA0 + n % 4));
    end

    // Two sources: grants alternate 0,2 and idle sources never see ready.
    do_reset;
    vin[1] = 4'b0101; din[1] = 32'hA3A2A1A0; rout[1] = 1'b1;
    @(negedge clk);
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      chk("alt_sel", 32'(sout[1]), 32'((n % 2) * 2));
      chk("alt_rdy13", 32'(rdy[1] & 4'b1010), 0);
    end

    // Passthrough lock: source 2 stays granted while stalled despite source 0.
    do_reset;
    vin[0] = 4'b0100; din[0] = 32'hC3C2C1C0; rout[0] = 1'b0;
    @(negedge clk);
    chk("lock_sel0", 32'(sout[0]), 2);
    chk("lock_vout0", 32'(vout[0]), 1);
    chk("lock_rdy0", 32'(rdy[0]), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    vin[0] = 4'b0101;
    repeat (3) begin
      @(negedge clk);
      chk("lock_sel", 32'(sout[0]), 2);
      chk("lock_data", 32'(dout[0]), 32'hC2);
      chk("lock_rdy", 32'(rdy[0]), 0);
    end
    rout[0] = 1'b1;
    #1;
    chk("lock_rel_rdy", 32'(rdy[0]), 32'b0100);
    chk("lock_rel_sel", 32'(sout[0]), 2);
    @(posedge clk); #1;
    vin[0] = 4'b0001;
    @(negedge clk);
    chk("after_lock_sel", 32'(sout[0]), 0);
    chk("after_lock_rdy", 32'(rdy[0]), 32'b0001);
    chk("after_lock_data", 32'(dout[0]), 32'hC0);

    // Reset while the skid buffer holds two entries.
    do_reset;
    for (int s = 0; s < 4; s++) pend[1][s] = 1'b1;
    rout[1] = 1'b0;
    drive_src(1);
    repeat (4) rcycle(1, 0, 3);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_vout", 32'(vout[1]), 0);
    chk("arst_rdy", 32'(rdy[1]), 0);
    chk("arst_data", 32'(dout[1]), 0);
    model_reset(1);
    pend[1][3] = 1'b1;
    rout[1] = 1'b1;
    drive_src(1);
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (4) rcycle(1, 0, 2);

    // Single-source build is pure wiring.
    for (int n = 0; n < 6; n++) begin
      vin1 = 1'($urandom_range(1));
      din1 = 8'($urandom);
      rout1 = 1'($urandom_range(1));
      #1;
      chk("one_vout", 32'(vout1), 32'(vin1));
      chk("one_data", 32'(dout1), 32'(din1));
      chk("one_rdy", 32'(rdy1), 32'(rout1));
      chk("one_sel", 32'(sout1), 0);
    end

    // Randomized traffic against the model.
    rphase(0, 40, 0, 300);
    rphase(1, 40, 0, 300);
    rphase(1, 90, 1, 200);
    rphase(2, 40, 0, 300);
    rphase(2, 90, 0, 200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
